servant_mtimer: RTL and testbench
=================================

SERVANT_MTIMER -- requirements
Module: servant_mtimer

Interface
REQ-001 Parameter PRESCALE, default 1, SHALL set the number of i_clk cycles per mtime increment (legal range 1..65535).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 i_wb_adr  input  2  SHALL be the word select, CPU address bits [3:2].
REQ-005 i_wb_dat  input  32  SHALL carry write data.
REQ-006 i_wb_sel  input  4  SHALL carry byte enables; bit n enables byte n of i_wb_dat.
REQ-007 i_wb_we  input  1  SHALL be write enable, 1=write, 0=read.
REQ-008 i_wb_cyc  input  1  SHALL be cycle valid; asserted by the initiator until ack is seen.
REQ-009 o_wb_rdt  output  32  SHALL be registered read data, valid in the o_wb_ack cycle.
REQ-010 o_wb_ack  output  1  SHALL be the single-cycle acknowledge.
REQ-011 o_irq  output  1  SHALL be the registered timer interrupt, level-sensitive.

Function
REQ-012 Register map SHALL be: word 0 mtime[31:0], word 1 mtime[63:32], word 2 mtimecmp[31:0], word 3 mtimecmp[63:32]; all read/write.
REQ-013 Handshake: o_wb_ack SHALL rise the cycle after i_wb_cyc=1 with o_wb_ack=0, stay high exactly one cycle, then fall; back-to-back cycles get ack every second cycle.
REQ-014 Read/write side effects SHALL occur only in the cycle with i_wb_cyc=1 and o_wb_ack=0 (the accept cycle); no side effect during the ack cycle.
REQ-015 Writes SHALL update only bytes with i_wb_sel bit set; i_wb_sel=0 writes nothing but is still acked.
REQ-016 Read at accept: word 0 SHALL return mtime[31:0] and simultaneously latch mtime[63:32] into a 32-bit shadow; word 1 SHALL return the shadow; words 2/3 return mtimecmp halves.
REQ-017 o_wb_rdt SHALL hold its last value on writes and idle cycles.
REQ-018 Prescaler: a counter SHALL count 0..PRESCALE-1 and wrap; mtime SHALL increment by 1 in the cycle the counter equals PRESCALE-1.
REQ-019 mtime SHALL be 64-bit unsigned and wrap from 2^64-1 to 0 without flag.
REQ-020 Write to mtime coinciding with an increment tick: written bytes SHALL take the written value; unwritten bytes of that word and the other word SHALL take the incremented value (carry included).
REQ-021 Any write to mtime SHALL reset the prescaler counter to 0.
REQ-022 o_irq SHALL be registered: next value = (mtime >= mtimecmp) using the values after this cycle's updates; one cycle latency from compare change to o_irq.
REQ-023 o_irq SHALL clear only by mtimecmp rising above mtime or mtime being written below mtimecmp; no separate clear register.
REQ-024 Writing mtimecmp halves individually SHALL be allowed; transient spurious o_irq between half writes is accepted behaviour.
REQ-025 i_wb_cyc dropped before ack SHALL not cancel the access; the ack still issues one cycle later.

Reset
REQ-026 On i_rst_n=0 at a clock edge: mtime=0, mtimecmp=64'hFFFFFFFF_FFFFFFFF, shadow=0, prescaler=0, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
REQ-027 Reset asserted mid-access SHALL abort it: no ack, no register update in that cycle; reset overrides all other updates.
REQ-028 After reset release the first increment SHALL occur PRESCALE cycles later.

Verification
REQ-029 PRESCALE=1, reset, idle 10 cycles, read word 0 -> o_wb_rdt in ack cycle equals mtime at accept (10 + elapsed), ack high exactly 1 cycle.
REQ-030 Write word 0 = 0xFFFFFFFF sel=4'hF, word 1 = 0 -> after tick mtime=0x1_00000000; read word 0 then word 1 -> word 1 returns shadow latched at word 0 read.
REQ-031 mtime=0, write mtimecmp lo=20, hi=0 -> o_irq=0 until mtime reaches 20, then o_irq=1 one cycle later; write mtimecmp lo=100 -> o_irq=0 within 1 cycle.
REQ-032 Write word 2 data 0xAABBCCDD sel=4'b0101 over reset value -> read word 2 returns 0xFFBBFFDD.
REQ-033 PRESCALE=4: mtime increments every 4 cycles; write mtime mid-period -> next increment exactly 4 cycles after the write.
REQ-034 Assert i_rst_n=0 in accept cycle of a write -> no ack next cycle, all registers at reset values.

Source files
------------

// File: rtl/servant_mtimer_if.sv
// servant_mtimer_if: Wishbone-style register bus for the machine timer.
//   i_wb_adr  word select (CPU address bits [3:2])
//   i_wb_dat  write data
//   i_wb_sel  byte enables, bit n enables byte n of i_wb_dat
//   i_wb_we   1 = write, 0 = read
//   i_wb_cyc  cycle valid, held by the initiator until ack
//   o_wb_rdt  registered read data, valid in the ack cycle
//   o_wb_ack  single-cycle acknowledge
// Signal names are seen from the timer (slave) side.
interface servant_mtimer_if;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr,
        output i_wb_dat,
        output i_wb_sel,
        output i_wb_we,
        output i_wb_cyc,
        input  o_wb_rdt,
        input  o_wb_ack
    );

    modport slave (
        input  i_wb_adr,
        input  i_wb_dat,
        input  i_wb_sel,
        input  i_wb_we,
        input  i_wb_cyc,
        output o_wb_rdt,
        output o_wb_ack
    );
endinterface

// File: rtl/servant_mtimer.sv
// servant_mtimer: 64-bit RISC-V style mtime/mtimecmp timer with a Wishbone register port.
//   i_clk    single clock, rising edge
//   i_rst_n  synchronous active-low reset
//   wb       register bus (slave modport): word 0/1 = mtime lo/hi, word 2/3 = mtimecmp lo/hi
//   o_irq    registered level interrupt, high while mtime >= mtimecmp
// PRESCALE sets the number of i_clk cycles per mtime increment (1..65535).
module servant_mtimer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    servant_mtimer_if.slave wb,
    output logic            o_irq
);

    localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] presc_q, presc_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        irq_q, irq_d;

    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic [63:0] mtime_inc;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // An access is taken only while no ack is outstanding, so back-to-back cycles
    // see one ack every second clock.
    assign accept    = wb.i_wb_cyc & ~ack_q;
    assign wr_en     = accept & wb.i_wb_we;
    assign rd_en     = accept & ~wb.i_wb_we;
    assign tick      = (presc_q == PresLast);
    assign mtime_inc = mtime_q + {63'd0, tick};

    always_comb begin
        // Written mtime bytes overlay the incremented value so a coinciding tick
        // still reaches the unwritten bytes and carries into the other word.
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        rdt_d      = rdt_q;
        presc_d    = tick ? 16'd0 : 16'(presc_q + 16'd1);

        if (wr_en) begin
            case (wb.i_wb_adr)
                2'd0: begin
                    mtime_d[31:0] = merge_bytes(mtime_inc[31:0], wb.i_wb_dat, wb.i_wb_sel);
                    presc_d       = 16'd0;
                end
                2'd1: begin
                    mtime_d[63:32] = merge_bytes(mtime_inc[63:32], wb.i_wb_dat, wb.i_wb_sel);
                    presc_d        = 16'd0;
                end
                2'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wb.i_wb_dat, wb.i_wb_sel);
                default: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb.i_wb_dat,
                                                         wb.i_wb_sel);
            endcase
        end

        if (rd_en) begin
            case (wb.i_wb_adr)
                2'd0: begin
                    // Snapshot the high word so a following word-1 read is coherent.
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                2'd1:    rdt_d = shadow_q;
                2'd2:    rdt_d = mtimecmp_q[31:0];
                default: rdt_d = mtimecmp_q[63:32];
            endcase
        end

        ack_d = accept;
        irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q   <= 32'd0;
            presc_q    <= 16'd0;
            ack_q      <= 1'b0;
            rdt_q      <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            presc_q    <= presc_d;
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            irq_q      <= irq_d;
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;
    assign o_irq       = irq_q;

endmodule

// File: tb/tb_servant_mtimer.sv
// tb_servant_mtimer: directed bench for servant_mtimer with PRESCALE=1 and PRESCALE=4 instances.
module tb_servant_mtimer;

    logic clk;
    logic rst_n;
    logic irq_p1;
    logic irq_p4;

    int checks;
    int failures;
    logic [31:0] last_rdt [2];

    servant_mtimer_if bus_p1 ();
    servant_mtimer_if bus_p4 ();

    servant_mtimer #(.PRESCALE(1)) u_dut_p1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus_p1),
        .o_irq   (irq_p1)
    );

    servant_mtimer #(.PRESCALE(4)) u_dut_p4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus_p4),
        .o_irq   (irq_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? bus_p1.o_wb_ack : bus_p4.o_wb_ack;
    endfunction

    function automatic logic [31:0] get_rdt(input int d);
        return (d == 0) ? bus_p1.o_wb_rdt : bus_p4.o_wb_rdt;
    endfunction

    function automatic logic get_irq(input int d);
        return (d == 0) ? irq_p1 : irq_p4;
    endfunction

    task automatic drive(input int d, input logic cyc, input logic we, input logic [1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (d == 0) begin
            bus_p1.i_wb_cyc = cyc; bus_p1.i_wb_we = we; bus_p1.i_wb_adr = adr;
            bus_p1.i_wb_dat = dat; bus_p1.i_wb_sel = sel;
        end else begin
            bus_p4.i_wb_cyc = cyc; bus_p4.i_wb_we = we; bus_p4.i_wb_adr = adr;
            bus_p4.i_wb_dat = dat; bus_p4.i_wb_sel = sel;
        end
    endtask

    // Accept on the next edge, cyc dropped right after it; ack must still follow.
    task automatic bus_write(input int d, input logic [1:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input string tag);
        drive(d, 1'b1, 1'b1, adr, dat, sel);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
        check_eq({tag, "_ack"}, {63'd0, get_ack(d)}, 64'd1);
        check_eq({tag, "_rdt_hold"}, {32'd0, get_rdt(d)}, {32'd0, last_rdt[d]});
        @(posedge clk); #1;
        check_eq({tag, "_ack_fall"}, {63'd0, get_ack(d)}, 64'd0);
    endtask

    task automatic bus_read(input int d, input logic [1:0] adr, input logic [31:0] exp,
                            input string tag);
        drive(d, 1'b1, 1'b0, adr, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
        check_eq({tag, "_ack"}, {63'd0, get_ack(d)}, 64'd1);
        check_eq({tag, "_rdt"}, {32'd0, get_rdt(d)}, {32'd0, exp});
        last_rdt[d] = exp;
        @(posedge clk); #1;
        check_eq({tag, "_ack_fall"}, {63'd0, get_ack(d)}, 64'd0);
        check_eq({tag, "_rdt_idle"}, {32'd0, get_rdt(d)}, {32'd0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_rdt[0] = 32'd0;
        last_rdt[1] = 32'd0;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ack", {63'd0, get_ack(d)}, 64'd0);
            check_eq("rst_rdt", {32'd0, get_rdt(d)}, 64'd0);
            check_eq("rst_irq", {63'd0, get_irq(d)}, 64'd0);
        end

        // ---- PRESCALE=1: mtime equals the number of edges since reset release
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus_read(0, 2'd0, 32'd10, "idle10_mtime_lo");

        // Low word wraps on the next tick; word 0 read latches high word = 1
        bus_write(0, 2'd1, 32'd0, 4'hF, "wr_hi0_a");
        bus_write(0, 2'd0, 32'hFFFF_FFFF, 4'hF, "wr_lo_ffff");
        bus_read(0, 2'd0, 32'h0000_0000, "carry_lo");
        bus_read(0, 2'd1, 32'h0000_0001, "carry_hi");

        // Shadow: high word becomes 1 between the two reads, shadow must keep 0
        bus_write(0, 2'd1, 32'd0, 4'hF, "wr_hi0_b");
        bus_write(0, 2'd0, 32'hFFFF_FFFE, 4'hF, "wr_lo_fffe");
        bus_read(0, 2'd0, 32'hFFFF_FFFF, "shadow_lo");
        bus_read(0, 2'd1, 32'h0000_0000, "shadow_hi");

        // Partial write coinciding with a tick that carries into the high word
        bus_write(0, 2'd1, 32'd0, 4'hF, "wr_hi0_c");
        bus_write(0, 2'd0, 32'hFFFF_FFFE, 4'hF, "wr_lo_fffe_b");
        bus_write(0, 2'd0, 32'h0000_0012, 4'b0001, "wr_tick_byte0");
        bus_read(0, 2'd0, 32'h0000_0013, "tick_wr_lo");
        bus_read(0, 2'd1, 32'h0000_0001, "tick_wr_hi");

        // Compare: irq rises with the edge that makes mtime 20
        bus_write(0, 2'd2, 32'd20, 4'hF, "cmp_lo20");
        check_eq("irq_cmp_half", {63'd0, irq_p1}, 64'd0);
        bus_write(0, 2'd1, 32'd0, 4'hF, "wr_hi0_d");
        bus_write(0, 2'd0, 32'd0, 4'hF, "wr_lo0");
        bus_write(0, 2'd3, 32'd0, 4'hF, "cmp_hi0");
        repeat (16) @(posedge clk);
        #1;
        check_eq("irq_at19", {63'd0, irq_p1}, 64'd0);
        @(posedge clk); #1;
        check_eq("irq_at20", {63'd0, irq_p1}, 64'd1);
        bus_write(0, 2'd2, 32'd100, 4'hF, "cmp_lo100");
        check_eq("irq_clr_cmp", {63'd0, irq_p1}, 64'd0);
        bus_write(0, 2'd2, 32'd0, 4'hF, "cmp_lo0");
        check_eq("irq_cmp0", {63'd0, irq_p1}, 64'd1);

        // Reset in the accept cycle of a write: no ack, everything back to reset
        drive(0, 1'b1, 1'b1, 2'd3, 32'h1234_5678, 4'hF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
        check_eq("rstacc_ack", {63'd0, bus_p1.o_wb_ack}, 64'd0);
        check_eq("rstacc_rdt", {32'd0, bus_p1.o_wb_rdt}, 64'd0);
        check_eq("rstacc_irq", {63'd0, irq_p1}, 64'd0);
        last_rdt[0] = 32'd0;
        rst_n = 1'b1;
        bus_read(0, 2'd1, 32'd0, "rstacc_shadow");
        bus_read(0, 2'd2, 32'hFFFF_FFFF, "rstacc_cmp_lo");
        bus_read(0, 2'd3, 32'hFFFF_FFFF, "rstacc_cmp_hi");
        bus_read(0, 2'd0, 32'd6, "rstacc_mtime");

        // ---- PRESCALE=4
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rdt[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        bus_read(1, 2'd0, 32'd0, "p4_first_pre");
        bus_read(1, 2'd0, 32'd1, "p4_first_post");
        repeat (2) @(posedge clk);
        #1;
        bus_write(1, 2'd0, 32'h0000_0100, 4'hF, "p4_wr_mid");
        @(posedge clk); #1;
        bus_read(1, 2'd0, 32'h0000_0100, "p4_no_early_tick");
        bus_read(1, 2'd0, 32'h0000_0101, "p4_tick_after4");

        // Byte enables on mtimecmp, and a sel=0 write that is acked but changes nothing
        bus_write(1, 2'd2, 32'hAABB_CCDD, 4'b0101, "p4_cmp_sel0101");
        bus_read(1, 2'd2, 32'hFFBB_FFDD, "p4_cmp_lo");
        bus_write(1, 2'd3, 32'h0000_0000, 4'b0000, "p4_cmp_sel0");
        bus_read(1, 2'd3, 32'hFFFF_FFFF, "p4_cmp_hi");
        check_eq("p4_irq", {63'd0, irq_p4}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
